// File: rtl/cc1200_spi_sched.sv
// cc1200_spi_sched: round-robin arbiter sharing one CC1200 SPI engine between config (port 0) and Tx (port 1),
// with start/completion watchdogs and a forced idle gap between transactions.
module cc1200_spi_sched #(
    parameter int BUSY_WAIT  = 16,
    parameter int TIMEOUT    = 4096,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [3:0]  req_wr0,
    input  logic [3:0]  req_wr1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        spi_start,
    input  logic        spi_busy,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wr,
    input  logic [31:0] spi_rdata,
    output logic        grant,
    output logic [7:0]  err_count
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, WAIT_BUSY = 3'd2, WAIT_DONE = 3'd3, GAP = 3'd4;
    logic [2:0]  state;
    logic [15:0] cnt, cnt_inc;
    logic [31:0] cnt_next;
    logic        last, gnt, take, fail, gap_done;
    logic [1:0]  rsp_vec;
    assign gnt       = &req_valid ? ~last : req_valid[1];
    // Launch is held off while the engine is still busy, e.g. after a completion timeout.
    assign take      = state == IDLE && |req_valid && !spi_busy;
    assign req_ready = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign spi_start = state == START;
    assign cnt_inc   = &cnt ? cnt : cnt + 16'd1;
    assign cnt_next  = {16'd0, cnt} + 32'd1;
    assign gap_done  = {16'd0, cnt} >= 32'(GAP_CYCLES);
    assign rsp_vec   = grant ? 2'b10 : 2'b01;
    assign fail      = state == WAIT_BUSY ? !spi_busy && cnt_next >= 32'(BUSY_WAIT)
                     : state == WAIT_DONE && spi_busy && cnt_next >= 32'(TIMEOUT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            spi_wdata <= '0;
            spi_wr    <= '0;
            grant     <= 1'b0;
            err_count <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (fail) begin
                rsp_valid <= rsp_vec;
                rsp_err   <= 1'b1;
                err_count <= &err_count ? err_count : err_count + 8'd1;
                cnt       <= '0;
                state     <= GAP;
            end else begin
                case (state)
                    IDLE: if (take) begin
                        spi_wdata <= gnt ? req_wdata1 : req_wdata0;
                        spi_wr    <= gnt ? req_wr1 : req_wr0;
                        grant     <= gnt;
                        last      <= gnt;
                        state     <= START;
                    end
                    START: begin
                        cnt   <= '0;
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        cnt   <= spi_busy ? '0 : cnt_inc;
                        state <= spi_busy ? WAIT_DONE : WAIT_BUSY;
                    end
                    WAIT_DONE: if (!spi_busy) begin
                        rsp_rdata <= spi_rdata;
                        rsp_valid <= rsp_vec;
                        cnt       <= '0;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                    GAP: begin
                        cnt   <= cnt_inc;
                        state <= gap_done ? IDLE : GAP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cc1200_spi_sched.sv
// tb_cc1200_spi_sched: directed bench for cc1200_spi_sched (default instance plus a zero-gap instance).
module tb_cc1200_spi_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [31:0] req_wdata0, req_wdata1, rsp_rdata, spi_wdata, spi_rdata;
    logic [3:0]  req_wr0, req_wr1, spi_wr;
    logic        rsp_err, spi_start, spi_busy, grant;
    logic [7:0]  err_count;

    logic [1:0]  z_req_valid, z_req_ready, z_rsp_valid;
    logic [31:0] z_req_wdata0, z_req_wdata1, z_rsp_rdata, z_spi_wdata, z_spi_rdata;
    logic [3:0]  z_req_wr0, z_req_wr1, z_spi_wr;
    logic        z_rsp_err, z_spi_start, z_spi_busy, z_grant;
    logic [7:0]  z_err_count;

    cc1200_spi_sched #(.BUSY_WAIT(16), .TIMEOUT(4096), .GAP_CYCLES(4)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_wr0(req_wr0), .req_wr1(req_wr1), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .spi_start(spi_start), .spi_busy(spi_busy),
        .spi_wdata(spi_wdata), .spi_wr(spi_wr), .spi_rdata(spi_rdata), .grant(grant), .err_count(err_count)
    );

    cc1200_spi_sched #(.BUSY_WAIT(16), .TIMEOUT(4096), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_wdata0(z_req_wdata0), .req_wdata1(z_req_wdata1),
        .req_wr0(z_req_wr0), .req_wr1(z_req_wr1), .req_ready(z_req_ready), .rsp_valid(z_rsp_valid),
        .rsp_err(z_rsp_err), .rsp_rdata(z_rsp_rdata), .spi_start(z_spi_start), .spi_busy(z_spi_busy),
        .spi_wdata(z_spi_wdata), .spi_wr(z_spi_wr), .spi_rdata(z_spi_rdata), .grant(z_grant), .err_count(z_err_count)
    );

    int tests = 0;
    int fails = 0;
    int c, fall, s, d, exp_cnt;
    logic leak;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(output int at);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 200) begin
            tick;
            n++;
        end
        chk("ready_timeout", 32'(n < 200), 32'd1);
        at = cyc;
    endtask

    task automatic wait_rsp;
        int n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin
            tick;
            n++;
        end
        chk("rsp_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        req_valid = '0; req_wdata0 = '0; req_wdata1 = '0; req_wr0 = '0; req_wr1 = '0;
        spi_busy = 1'b0; spi_rdata = '0;
        z_req_valid = '0; z_req_wdata0 = '0; z_req_wdata1 = '0; z_req_wr0 = '0; z_req_wr1 = '0;
        z_spi_busy = 1'b0; z_spi_rdata = '0;
        tick;
        tick;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_wdata", spi_wdata, 32'd0);
        chk("rst_spi_wr", 32'(spi_wr), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick;

        // single read on port 0
        req_wdata0 = 32'hAF2F0000; req_wr0 = 4'hC; req_wdata1 = 32'h11112222; req_wr1 = 4'h3;
        req_valid = 2'b01;
        #1 chk("t1_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 2'b00;
        chk("t1_start", 32'(spi_start), 32'd1);
        chk("t1_spi_wdata", spi_wdata, 32'hAF2F0000);
        chk("t1_spi_wr", 32'(spi_wr), 32'hC);
        chk("t1_grant", 32'(grant), 32'd0);
        tick;
        chk("t1_start_pulse", 32'(spi_start), 32'd0);
        spi_busy = 1'b1;
        spi_rdata = 32'h00001234;
        repeat (40) tick;
        spi_busy = 1'b0;
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_err", 32'(rsp_err), 32'd0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h00001234);
        tick;
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

        // contention: both ports always requesting
        do_reset;
        req_wdata0 = 32'hA0A0A0A0; req_wdata1 = 32'hB1B1B1B1;
        req_valid = 2'b11;
        fall = 0;
        for (int t = 0; t < 6; t++) begin
            wait_ready(c);
            chk($sformatf("c%0d_ready", t), 32'(req_ready), (t % 2) ? 32'd2 : 32'd1);
            if (t > 0) chk($sformatf("c%0d_turnaround", t), 32'(c - fall), 32'd6);
            tick;
            chk($sformatf("c%0d_grant", t), 32'(grant), 32'(t % 2));
            chk($sformatf("c%0d_wdata", t), spi_wdata, (t % 2) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
            tick;
            spi_busy = 1'b1;
            spi_rdata = 32'hC000 + 32'(t);
            repeat (3) tick;
            spi_busy = 1'b0;
            fall = cyc;
            tick;
            chk($sformatf("c%0d_rsp", t), 32'(rsp_valid), (t % 2) ? 32'd2 : 32'd1);
            chk($sformatf("c%0d_rdata", t), rsp_rdata, 32'hC000 + 32'(t));
        end
        req_valid = 2'b00;

        // engine never raises busy
        req_valid = 2'b01;
        wait_ready(c);
        tick;
        req_valid = 2'b00;
        tick;
        s = cyc;
        repeat (15) tick;
        chk("nb_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick;
        chk("nb_delay", 32'(cyc - s), 32'd16);
        chk("nb_rsp", 32'(rsp_valid), 32'd1);
        chk("nb_err", 32'(rsp_err), 32'd1);
        chk("nb_rdata_kept", rsp_rdata, 32'hC005);
        chk("nb_err_count", 32'(err_count), 32'd1);

        // engine stuck busy with port 1 waiting
        req_valid = 2'b01;
        wait_ready(c);
        tick;
        req_valid = 2'b10;
        tick;
        spi_busy = 1'b1;
        tick;
        d = cyc;
        repeat (4095) tick;
        chk("sb_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick;
        chk("sb_rsp", 32'(rsp_valid), 32'd1);
        chk("sb_err", 32'(rsp_err), 32'd1);
        chk("sb_rdata_kept", rsp_rdata, 32'hC005);
        chk("sb_err_count", 32'(err_count), 32'd2);
        leak = 1'b0;
        repeat (98) begin
            tick;
            leak = leak | (req_ready != 2'b00);
        end
        chk("sb_busy_blocks", 32'(leak), 32'd0);
        spi_busy = 1'b0;
        #1 chk("sb_p1_ready", 32'(req_ready), 32'd2);
        tick;
        req_valid = 2'b00;
        chk("sb_p1_grant", 32'(grant), 32'd1);
        tick;
        spi_busy = 1'b1;
        spi_rdata = 32'h00005A5A;
        tick;
        spi_busy = 1'b0;
        tick;
        chk("sb_p1_rsp", 32'(rsp_valid), 32'd2);
        chk("sb_p1_err", 32'(rsp_err), 32'd0);
        chk("sb_p1_rdata", rsp_rdata, 32'h00005A5A);

        // error counter saturation
        exp_cnt = 2;
        for (int i = 0; i < 260; i++) begin
            req_valid = 2'b01;
            wait_ready(c);
            tick;
            req_valid = 2'b00;
            wait_rsp;
            exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
            chk($sformatf("sat%0d_err", i), 32'(rsp_err), 32'd1);
            chk($sformatf("sat%0d_count", i), 32'(err_count), 32'(exp_cnt));
        end

        // zero-gap instance: next grant right after the response
        z_req_wdata0 = 32'hDEAD0001; z_req_wr0 = 4'hF; z_req_wdata1 = 32'hBEEF0002; z_req_wr1 = 4'h1;
        z_req_valid = 2'b01;
        #1 chk("z_ready0", 32'(z_req_ready), 32'd1);
        tick;
        z_req_valid = 2'b10;
        tick;
        z_spi_busy = 1'b1;
        z_spi_rdata = 32'h77;
        tick;
        z_spi_busy = 1'b0;
        tick;
        chk("z_rsp", 32'(z_rsp_valid), 32'd1);
        chk("z_rdata", z_rsp_rdata, 32'h77);
        chk("z_gap_ready", 32'(z_req_ready), 32'd0);
        tick;
        #1 chk("z_ready1", 32'(z_req_ready), 32'd2);
        tick;
        z_req_valid = 2'b00;
        chk("z_start", 32'(z_spi_start), 32'd1);
        chk("z_grant", 32'(z_grant), 32'd1);
        chk("z_spi_wdata", z_spi_wdata, 32'hBEEF0002);
        chk("z_err_count", 32'(z_err_count), 32'd0);

        // reset while in WAIT_DONE
        req_valid = 2'b01;
        wait_ready(c);
        tick;
        req_valid = 2'b00;
        tick;
        spi_busy = 1'b1;
        spi_rdata = 32'h9999;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_rsp_err", 32'(rsp_err), 32'd0);
        chk("rm_rsp_rdata", rsp_rdata, 32'd0);
        chk("rm_spi_start", 32'(spi_start), 32'd0);
        chk("rm_spi_wdata", spi_wdata, 32'd0);
        chk("rm_spi_wr", 32'(spi_wr), 32'd0);
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_err_count", 32'(err_count), 32'd0);
        tick;
        rst = 1'b0;
        spi_busy = 1'b0;
        leak = 1'b0;
        repeat (10) begin
            tick;
            leak = leak | (rsp_valid != 2'b00);
        end
        chk("rm_no_rsp", 32'(leak), 32'd0);
        req_valid = 2'b11;
        #1 chk("rm_first_tie", 32'(req_ready), 32'd1);
        tick;
        req_valid = 2'b00;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cc1200_spi_sched.md
# cc1200_spi_sched

- Round-robin scheduler that shares one CC1200 SPI transaction engine between two requesters:
  - port 0: radio configuration/strobe commands;
  - port 1: Tx data path.
- Per transaction it accepts a request, launches the engine, and supervises its busy handshake with start and completion watchdogs.
- It returns the read-back word to the owning requester, then enforces a minimum idle gap before the next start.
- Sits between the requesters and the engine's Start/Busy/DataOut/DataIn/WR inputs, in the engine's clock domain.

## Interface
Parameters:
- BUSY_WAIT, 16: cycles allowed after spi_start for spi_busy to rise.
- TIMEOUT, 4096: cycles allowed for spi_busy to stay high.
- GAP_CYCLES, 4: idle cycles forced between transactions; 0 allowed.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active high.
- req_valid  in  2  per-port request; held until req_ready.
- req_wdata0 / req_wdata1  in  32  bytes to send, MSB byte first.
- req_wr0 / req_wr1  in  4  byte-length mask passed to the engine WR input.
- req_ready  out  2  one-cycle accept pulse, one-hot.
- rsp_valid  out  2  one-cycle completion pulse to the granted port.
- rsp_err  out  1  qualifies rsp_valid; 1 means a watchdog expired.
- rsp_rdata  out  32  engine read word, valid with rsp_valid.
- spi_start  out  1  one-cycle launch pulse.
- spi_busy  in  1  engine busy.
- spi_wdata  out  32  latched request data.
- spi_wr  out  4  latched request mask.
- spi_rdata  in  32  engine read word.
- grant  out  1  port currently owning the engine.
- err_count  out  8  saturating watchdog-error counter.

## Operation
States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.

- **IDLE**
  - Arbitrates only when spi_busy = 0; otherwise waits.
  - Single valid port wins.
  - Both valid: the winner is the port not granted last.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
  - On a grant, in the same cycle: pulse req_ready[g], latch wdata/wr into spi_wdata/spi_wr, set grant = g, move to START.
- **START**
  - spi_start = 1 for exactly this cycle.
  - Clears the watchdog counter; next state is WAIT_BUSY.
- **WAIT_BUSY**
  - spi_busy = 1: go to WAIT_DONE, clearing the counter.
  - Counter reaches BUSY_WAIT with no busy: pulse rsp_valid[g] with rsp_err = 1 and rsp_rdata unchanged, then go to GAP.
- **WAIT_DONE**
  - spi_busy falls: capture spi_rdata into rsp_rdata, pulse rsp_valid[g] with rsp_err = 0, go to GAP.
  - Counter reaches TIMEOUT first: error response as above, go to GAP.
  - The engine is not aborted; IDLE's spi_busy = 0 condition blocks the next launch until it finishes.
- **GAP**
  - Counts GAP_CYCLES cycles, then returns to IDLE.
  - With GAP_CYCLES = 0, returns to IDLE on the next cycle.
- **Error counting:** err_count increments on every error response and saturates at 255; it is cleared only by reset.
- **Stable outputs:** spi_wdata, spi_wr and grant hold from the grant until the next grant.
- **Ignored requests:** req_valid changing while not in IDLE has no effect.
- **Watchdog counter:** 16 bits wide, saturating. BUSY_WAIT and TIMEOUT must be ≤ 65535.

## Timing
- **Reset values:** state IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, spi_start = 0, spi_wdata = 0, spi_wr = 0, grant = 0, err_count = 0, last-grant = 1.
- **Request to start:** req_valid seen in IDLE at cycle 0 → req_ready at cycle 0 → spi_start at cycle 1.
- **Completion:** spi_busy sampled low at cycle n in WAIT_DONE → rsp_valid at cycle n+1, registered.
- **Turnaround:** minimum rsp_valid to next req_ready is GAP_CYCLES + 1 cycles.
- **Back-to-back, same port:** allowed when the other port is idle.
- **Reset mid-transaction:** all state returns to reset values immediately; no rsp_valid is issued for the aborted request.

## Test plan
- **Single read:** port 0 requests wdata=0xAF2F0000, wr=4'hC; engine busy for 40 cycles, returns 0x00001234.
  - Expect req_ready[0] at cycle 0 and spi_start at cycle 1.
  - Expect rsp_valid[0] one cycle after busy falls, with rsp_err = 0 and rsp_rdata = 0x00001234.
- **Contention:** both ports request continuously for 6 transactions.
  - Grants alternate 0,1,0,1,0,1.
  - Each start is separated from the previous busy-fall by ≥ GAP_CYCLES + 1 cycles.
- **No-busy watchdog:** engine never asserts busy.
  - rsp_valid with rsp_err = 1 exactly BUSY_WAIT cycles after entering WAIT_BUSY.
  - err_count = 1.
- **Stuck-busy watchdog:** busy held high for TIMEOUT + 100 cycles.
  - Error response at TIMEOUT.
  - A pending port 1 request is not granted until busy drops.
- **Saturation and zero gap:** force 260 errors, then a good transaction with GAP_CYCLES = 0.
  - err_count stays 255.
  - Next grant occurs two cycles after rsp_valid.
- **Reset mid-transaction:** assert rst while in WAIT_DONE.
  - All outputs return to reset values.
  - No rsp_valid appears.
  - The first tie after reset grants port 0.
